// File: rtl/vga_axi_pkg.sv
// Shared types and constants for the VGA line-fetch AXI read master.
// The FSM state encoding, fixed AXI burst attributes and line geometry helper.
package vga_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    NEXT,
    DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  // AXI ARSIZE encoding: log2 of the number of bytes per beat.
  function automatic logic [2:0] axi_size_enc(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

  function automatic int words_per_line(input int burst_len, input int n_bursts);
    return burst_len * n_bursts;
  endfunction

endpackage

// File: rtl/axi_full_vga_if.sv
// AXI4 read master fetching one video line per VGA request into one of two
// ping-pong line buffers, one registered BRAM write per accepted R beat.
module axi_full_vga_if
  import vga_axi_pkg::*;
#(
  parameter int                            BRAM_ADDR_WIDTH                = 32,
  parameter int                            C_M_AXI_ADDR_WIDTH             = 32,
  parameter int                            C_M_AXI_DATA_WIDTH             = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR     = 32'h0,
  parameter int                            C_M_AXI_BURST_LEN              = 32,
  parameter int                            C_M_AXI_NUMBER_OF_BURST        = 25,
  parameter int                            C_BITS_WIDTH_FOR_NUMB_OF_BURST = 5,
  parameter int                            C_LINES_PER_FRAME              = 480
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          VGA_READY,
  output logic                          AXI_VGA_READY,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  input  logic                          M_AXI_ARREADY,
  output logic                          M_AXI_ARVALID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  output logic                          M_AXI_RREADY,
  input  logic                          M_AXI_RVALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0] DATA_OUT_1,
  output logic                          WE_1,
  output logic [BRAM_ADDR_WIDTH-1:0]    BRAM_WRADDR_1,
  output logic [C_M_AXI_DATA_WIDTH-1:0] DATA_OUT_2,
  output logic                          WE_2,
  output logic [BRAM_ADDR_WIDTH-1:0]    BRAM_WRADDR_2
);

  localparam int LINE_W = (C_LINES_PER_FRAME > 1) ? $clog2(C_LINES_PER_FRAME) : 1;
  localparam int BURST_W = C_BITS_WIDTH_FOR_NUMB_OF_BURST;

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BYTES_PER_BURST =
    C_M_AXI_ADDR_WIDTH'(C_M_AXI_BURST_LEN * (C_M_AXI_DATA_WIDTH / 8));
  localparam logic [BRAM_ADDR_WIDTH-1:0] WORDS_PER_BURST = BRAM_ADDR_WIDTH'(C_M_AXI_BURST_LEN);
  localparam logic [BURST_W-1:0]         LAST_BURST      = BURST_W'(C_M_AXI_NUMBER_OF_BURST - 1);
  localparam logic [LINE_W-1:0]          LAST_LINE       = LINE_W'(C_LINES_PER_FRAME - 1);

  state_t                          state;
  logic [BURST_W-1:0]              burst_cnt;
  logic [LINE_W-1:0]               line_cnt;
  logic [BRAM_ADDR_WIDTH-1:0]      beat_cnt;
  logic [BRAM_ADDR_WIDTH-1:0]      word_base;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   next_addr;
  logic                            use_buf2;
  logic [BRAM_ADDR_WIDTH-1:0]      wr_idx;
  logic                            unused_rresp;

  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
  assign M_AXI_ARSIZE  = axi_size_enc(C_M_AXI_DATA_WIDTH);
  assign unused_rresp  = ^M_AXI_RRESP;

  // word_base tracks burst_cnt*BURST_LEN so the write index needs no multiplier.
  assign wr_idx = word_base + beat_cnt;

  // next_addr walks the frame burst by burst; since lines are contiguous in
  // memory this equals BASE + (line_cnt*NB + burst_cnt)*bytes_per_burst.
  // NOTE: reset here is synchronous and active-high despite the AXI-style name;
  // every register, including the write-port data, is cleared while it is high.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESETN) begin
      state         <= IDLE;
      burst_cnt     <= '0;
      line_cnt      <= '0;
      beat_cnt      <= '0;
      word_base     <= '0;
      next_addr     <= C_M_TARGET_SLAVE_BASE_ADDR;
      use_buf2      <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      AXI_VGA_READY <= 1'b0;
      WE_1          <= 1'b0;
      DATA_OUT_1    <= '0;
      BRAM_WRADDR_1 <= '0;
      WE_2          <= 1'b0;
      DATA_OUT_2    <= '0;
      BRAM_WRADDR_2 <= '0;
    end else begin
      WE_1          <= 1'b0;
      WE_2          <= 1'b0;
      AXI_VGA_READY <= 1'b0;
      case (state)
        IDLE: begin
          if (VGA_READY) begin
            M_AXI_ARADDR  <= next_addr;
            M_AXI_ARVALID <= 1'b1;
            burst_cnt     <= '0;
            word_base     <= '0;
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            beat_cnt      <= '0;
            next_addr     <= next_addr + BYTES_PER_BURST;
            state         <= DATA;
          end
        end
        DATA: begin
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            if (use_buf2) begin
              WE_2          <= 1'b1;
              DATA_OUT_2    <= M_AXI_RDATA;
              BRAM_WRADDR_2 <= wr_idx;
            end else begin
              WE_1          <= 1'b1;
              DATA_OUT_1    <= M_AXI_RDATA;
              BRAM_WRADDR_1 <= wr_idx;
            end
            beat_cnt <= beat_cnt + 1'b1;
            if (M_AXI_RLAST) begin
              M_AXI_RREADY <= 1'b0;
              state        <= NEXT;
            end
          end
        end
        NEXT: begin
          if (burst_cnt == LAST_BURST) begin
            AXI_VGA_READY <= 1'b1;
            state         <= DONE;
          end else begin
            burst_cnt     <= burst_cnt + 1'b1;
            word_base     <= word_base + WORDS_PER_BURST;
            M_AXI_ARADDR  <= next_addr;
            M_AXI_ARVALID <= 1'b1;
            state         <= ADDR;
          end
        end
        DONE: begin
          use_buf2 <= ~use_buf2;
          if (line_cnt == LAST_LINE) begin
            line_cnt  <= '0;
            next_addr <= C_M_TARGET_SLAVE_BASE_ADDR;
          end else begin
            line_cnt <= line_cnt + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_full_vga_if.sv
// Scoreboard bench for axi_full_vga_if: drives AXI AR/R traffic for whole lines
// and checks every BRAM write, the address sequence and the line-done pulse.
module tb_axi_full_vga_if;
  import vga_axi_pkg::*;

  localparam int BL    = 32;
  localparam int NB    = 25;
  localparam int LINES = 480;
  localparam int WPL   = words_per_line(BL, NB);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vga_ready = 1'b0;
  logic        axi_vga_ready;
  logic [1:0]  m_axi_arburst;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic        m_axi_arready = 1'b0;
  logic        m_axi_arvalid;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rready;
  logic        m_axi_rvalid = 1'b0;
  logic [31:0] data_out_1, data_out_2;
  logic        we_1, we_2;
  logic [31:0] bram_wraddr_1, bram_wraddr_2;

  typedef struct {
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  sb_q[$];
  wr_t  mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ready_pulses = 0;
  int   ar_starts = 0;
  logic arvalid_q = 1'b0;
  int   model_line = 0;
  int   model_port = 1;

  axi_full_vga_if dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst),
    .VGA_READY     (vga_ready),
    .AXI_VGA_READY (axi_vga_ready),
    .M_AXI_ARBURST (m_axi_arburst),
    .M_AXI_ARADDR  (m_axi_araddr),
    .M_AXI_ARLEN   (m_axi_arlen),
    .M_AXI_ARSIZE  (m_axi_arsize),
    .M_AXI_ARREADY (m_axi_arready),
    .M_AXI_ARVALID (m_axi_arvalid),
    .M_AXI_RDATA   (m_axi_rdata),
    .M_AXI_RRESP   (m_axi_rresp),
    .M_AXI_RLAST   (m_axi_rlast),
    .M_AXI_RREADY  (m_axi_rready),
    .M_AXI_RVALID  (m_axi_rvalid),
    .DATA_OUT_1    (data_out_1),
    .WE_1          (we_1),
    .BRAM_WRADDR_1 (bram_wraddr_1),
    .DATA_OUT_2    (data_out_2),
    .WE_2          (we_2),
    .BRAM_WRADDR_2 (bram_wraddr_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write-port monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (m_axi_arvalid && !arvalid_q) ar_starts++;
    arvalid_q = m_axi_arvalid;
    if (axi_vga_ready) ready_pulses++;
    if (we_1 || we_2) begin
      if (sb_q.size() == 0) begin
        check("spurious_we", 32'({we_1, we_2}), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("we_port", 32'({we_1, we_2}), 32'(mon_e.we));
        if (we_1) begin
          check("wraddr_1", bram_wraddr_1, mon_e.addr);
          check("data_1", data_out_1, mon_e.data);
        end else begin
          check("wraddr_2", bram_wraddr_2, mon_e.addr);
          check("data_2", data_out_2, mon_e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_arvalid"}, 32'(m_axi_arvalid), 32'd0);
    check({tag, "_rready"}, 32'(m_axi_rready), 32'd0);
    check({tag, "_vga_ready"}, 32'(axi_vga_ready), 32'd0);
    check({tag, "_we"}, 32'({we_1, we_2}), 32'd0);
    check({tag, "_araddr"}, m_axi_araddr, 32'd0);
  endtask

  task automatic do_ar(input logic [31:0] exp_addr);
    int guard = 0;
    while (!m_axi_arvalid && guard < 20) begin
      step();
      guard++;
    end
    check("arvalid_seen", 32'(m_axi_arvalid), 32'd1);
    check("araddr", m_axi_araddr, exp_addr);
    if ($urandom_range(0, 1) == 1) begin
      step();
      check("araddr_stable", m_axi_araddr, exp_addr);
    end
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    check("arvalid_drop", 32'(m_axi_arvalid), 32'd0);
    check("rready_rise", 32'(m_axi_rready), 32'd1);
  endtask

  task automatic drive_beat(input logic [31:0] data, input logic last, input wr_t e);
    int guard = 0;
    if ($urandom_range(0, 3) == 0) begin
      m_axi_rvalid = 1'b0;
      step();
    end
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = data;
    m_axi_rlast  = last;
    while (!m_axi_rready && guard < 20) begin
      step();
      guard++;
    end
    check("rready_for_beat", 32'(m_axi_rready), 32'd1);
    sb_q.push_back(e);
    step();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  task automatic run_line(input bit hold_req, input bit first_pattern);
    logic [1:0]  exp_we;
    logic [31:0] data;
    logic [31:0] exp_addr;
    exp_we       = (model_port == 1) ? 2'b10 : 2'b01;
    ar_starts    = 0;
    ready_pulses = 0;
    vga_ready    = 1'b1;
    step();
    if (!hold_req) vga_ready = 1'b0;
    check("arvalid_latency", 32'(m_axi_arvalid), 32'd1);
    for (int b = 0; b < NB; b++) begin
      exp_addr = 32'((model_line * NB + b) * BL * 4);
      do_ar(exp_addr);
      for (int i = 0; i < BL; i++) begin
        if (first_pattern && b == 0) data = (i == BL - 1) ? 32'd2 : 32'(i);
        else data = $urandom;
        drive_beat(data, i == BL - 1, '{we: exp_we, addr: 32'(b * BL + i), data: data});
      end
      check("rready_after_rlast", 32'(m_axi_rready), 32'd0);
      if (b == NB - 1) begin
        step();
        check("line_done_pulse", 32'(axi_vga_ready), 32'd1);
        vga_ready = 1'b0;
        step();
        check("line_done_single", 32'(axi_vga_ready), 32'd0);
      end
    end
    step();
    step();
    check("ready_pulse_count", 32'(ready_pulses), 32'd1);
    check("ar_count", 32'(ar_starts), 32'(NB));
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("last_wraddr", (model_port == 1) ? bram_wraddr_1 : bram_wraddr_2, 32'(WPL - 1));
    check("idle_arvalid", 32'(m_axi_arvalid), 32'd0);
    model_port = 3 - model_port;
    model_line = (model_line + 1) % LINES;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (10) step();
    check_quiet("reset");
    check("reset_data_1", data_out_1, 32'd0);
    check("reset_wraddr_2", bram_wraddr_2, 32'd0);
    check("arlen", 32'(m_axi_arlen), 32'd31);
    check("arsize", 32'(m_axi_arsize), 32'(AXI_SIZE_4B));
    check("arburst", 32'(m_axi_arburst), 32'(AXI_BURST_INCR));
    rst = 1'b0;
    step();
    check_quiet("post_reset");

    run_line(1'b0, 1'b1);
    run_line(1'b0, 1'b0);
    run_line(1'b1, 1'b0);
    run_line(1'b0, 1'b0);
    run_line(1'b0, 1'b0);

    // Abandon a line part-way through a burst.
    vga_ready = 1'b1;
    step();
    vga_ready = 1'b0;
    do_ar(32'(model_line * NB * BL * 4));
    for (int i = 0; i < 10; i++) begin
      drive_beat(32'(i + 100), 1'b0,
                 '{we: (model_port == 1) ? 2'b10 : 2'b01, addr: 32'(i), data: 32'(i + 100)});
    end
    m_axi_rvalid = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    check_quiet("mid_reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rready_after_release", 32'(m_axi_rready), 32'd0);
      check("we_after_release", 32'({we_1, we_2}), 32'd0);
    end
    m_axi_rvalid = 1'b0;
    check("sb_after_reset", 32'(sb_q.size()), 32'd0);
    model_line = 0;
    model_port = 1;
    run_line(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
